// File: rtl/full_subtractor_dataflow.sv
// Registered subtract-with-borrow cell: {c_out, diff} = x - y - c_in.
// The difference is formed by an explicit ripple-borrow chain, one cell
// per bit, and captured in output registers for a single cycle of latency.
// Outputs hold their last captured value while in_valid is low.
module full_subtractor_dataflow #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             c_in,
    output logic [WIDTH-1:0] diff,
    output logic             c_out,
    output logic             out_valid
);

    // borrow[i] is the borrow into bit i; borrow[0] is the external borrow-in
    logic [WIDTH:0]   borrow;
    logic [WIDTH-1:0] diff_comb;

    assign borrow[0] = c_in;

    // Ripple-borrow chain: each cell produces its difference bit and the
    // borrow it passes to the next more-significant cell.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign diff_comb[i]  = x[i] ^ y[i] ^ borrow[i];
        assign borrow[i + 1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & borrow[i]);
    end

    // Output registers: reset clears everything and wins over in_valid;
    // otherwise capture on in_valid and hold the result when idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            diff      <= '0;
            c_out     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                diff  <= diff_comb;
                c_out <= borrow[WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_full_subtractor_dataflow.sv
// Directed and random checks of the registered full subtractor at
// WIDTH=1 (exhaustive truth table) and WIDTH=4 (multi-bit and wrap cases).
module tb_full_subtractor_dataflow;

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic       c_in;
        logic [3:0] diff;
        logic       c_out;
    } vec_t;

    logic       clk;
    logic       rst_n;

    logic       v1_in, v1_out;
    logic       x1, y1, c1, d1, b1;

    logic       v4_in, v4_out;
    logic [3:0] x4, y4, d4;
    logic       c4, b4;

    int checks;
    int errors;

    vec_t tbl1[8];
    vec_t tbl4[7];

    full_subtractor_dataflow #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v1_in),
        .x         (x1),
        .y         (y1),
        .c_in      (c1),
        .diff      (d1),
        .c_out     (b1),
        .out_valid (v1_out)
    );

    full_subtractor_dataflow #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v4_in),
        .x         (x4),
        .y         (y4),
        .c_in      (c4),
        .diff      (d4),
        .c_out     (b4),
        .out_valid (v4_out)
    );

    // free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // advance one rising edge, then settle 1 time unit before sampling/driving
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic v, input logic [3:0] xa, input logic [3:0] ya, input logic ca);
        v4_in = v;
        x4    = xa;
        y4    = ya;
        c4    = ca;
    endtask

    task automatic chk4(input string name, input logic [3:0] ed, input logic eb, input logic ev);
        chk({name, " diff"},  8'(d4),     8'(ed));
        chk({name, " c_out"}, 8'(b4),     8'(eb));
        chk({name, " valid"}, 8'(v4_out), 8'(ev));
    endtask

    initial begin
        logic [4:0] gold;
        logic [3:0] rx, ry;
        logic       rc;

        checks = 0;
        errors = 0;

        // WIDTH=1 truth table: x y c_in -> diff c_out
        tbl1[0] = '{4'd0, 4'd0, 1'b0, 4'd0, 1'b0};
        tbl1[1] = '{4'd0, 4'd0, 1'b1, 4'd1, 1'b1};
        tbl1[2] = '{4'd0, 4'd1, 1'b0, 4'd1, 1'b1};
        tbl1[3] = '{4'd0, 4'd1, 1'b1, 4'd0, 1'b1};
        tbl1[4] = '{4'd1, 4'd0, 1'b0, 4'd1, 1'b0};
        tbl1[5] = '{4'd1, 4'd0, 1'b1, 4'd0, 1'b0};
        tbl1[6] = '{4'd1, 4'd1, 1'b0, 4'd0, 1'b0};
        tbl1[7] = '{4'd1, 4'd1, 1'b1, 4'd1, 1'b1};

        // WIDTH=4 directed cases, hand computed
        tbl4[0] = '{4'h9, 4'h3, 1'b0, 4'h6, 1'b0};
        tbl4[1] = '{4'h3, 4'h9, 1'b1, 4'h9, 1'b1};
        tbl4[2] = '{4'h0, 4'hF, 1'b1, 4'h0, 1'b1};
        tbl4[3] = '{4'hF, 4'hF, 1'b0, 4'h0, 1'b0};
        tbl4[4] = '{4'h5, 4'h5, 1'b1, 4'hF, 1'b1};
        tbl4[5] = '{4'h8, 4'h1, 1'b0, 4'h7, 1'b0};
        tbl4[6] = '{4'hA, 4'h3, 1'b1, 4'h6, 1'b0};

        // reset with in_valid high for two cycles: inputs must be dropped
        rst_n = 1'b0;
        v1_in = 1'b1; x1 = 1'b0; y1 = 1'b1; c1 = 1'b1;
        drive4(1'b1, 4'h3, 4'h9, 1'b1);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("rst w1 diff",  8'(d1),     8'h00);
            chk("rst w1 c_out", 8'(b1),     8'h00);
            chk("rst w1 valid", 8'(v1_out), 8'h00);
            chk4("rst w4", 4'h0, 1'b0, 1'b0);
        end
        rst_n = 1'b1;
        v1_in = 1'b0;
        drive4(1'b0, 4'h0, 4'h0, 1'b0);
        step();
        chk("idle w1 valid", 8'(v1_out), 8'h00);

        // WIDTH=1 exhaustive, back to back
        for (int i = 0; i < 8; i++) begin
            v1_in = 1'b1;
            x1 = tbl1[i].x[0];
            y1 = tbl1[i].y[0];
            c1 = tbl1[i].c_in;
            step();
            chk($sformatf("w1 vec%0d diff", i),  8'(d1),     8'(tbl1[i].diff[0]));
            chk($sformatf("w1 vec%0d c_out", i), 8'(b1),     8'(tbl1[i].c_out));
            chk($sformatf("w1 vec%0d valid", i), 8'(v1_out), 8'h01);
        end
        v1_in = 1'b0;
        x1 = 1'b0; y1 = 1'b0; c1 = 1'b0;
        step();
        chk("w1 hold valid", 8'(v1_out), 8'h00);
        chk("w1 hold diff",  8'(d1),     8'h01);
        chk("w1 hold c_out", 8'(b1),     8'h01);

        // WIDTH=4 directed, back to back
        for (int i = 0; i < 7; i++) begin
            drive4(1'b1, tbl4[i].x, tbl4[i].y, tbl4[i].c_in);
            step();
            chk4($sformatf("w4 vec%0d", i), tbl4[i].diff, tbl4[i].c_out, 1'b1);
        end

        // hold: result 9/1, then idle with different operands on the inputs
        drive4(1'b1, 4'h3, 4'h9, 1'b1);
        step();
        chk4("hold load", 4'h9, 1'b1, 1'b1);
        drive4(1'b0, 4'hF, 4'h0, 1'b0);
        step();
        chk4("hold c1", 4'h9, 1'b1, 1'b0);
        step();
        chk4("hold c2", 4'h9, 1'b1, 1'b0);

        // mid-stream reset
        drive4(1'b1, 4'h9, 4'h3, 1'b0);
        step();
        chk4("mid pre", 4'h6, 1'b0, 1'b1);
        rst_n = 1'b0;
        drive4(1'b1, 4'h5, 4'h2, 1'b0);
        step();
        chk4("mid rst", 4'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
        drive4(1'b1, 4'h2, 4'h5, 1'b0);
        step();
        chk4("mid resume", 4'hD, 1'b1, 1'b1);
        drive4(1'b1, 4'hC, 4'h4, 1'b1);
        step();
        chk4("mid resume2", 4'h7, 1'b0, 1'b1);

        // random vectors against the arithmetic golden model
        for (int i = 0; i < 24; i++) begin
            rx = 4'($urandom_range(0, 15));
            ry = 4'($urandom_range(0, 15));
            rc = 1'($urandom_range(0, 1));
            gold = {1'b0, rx} - {1'b0, ry} - {4'b0, rc};
            drive4(1'b1, rx, ry, rc);
            step();
            chk4($sformatf("rand%0d %0h-%0h-%0d", i, rx, ry, rc), gold[3:0], gold[4], 1'b1);
        end
        drive4(1'b0, 4'h0, 4'h0, 1'b0);
        step();
        chk("final valid", 8'(v4_out), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
